// File: rtl/fetch_pc_unit.sv
// F1 fetch stage: owns the fetch PC and predicts a 2-wide fetch group (pc, pc+4).
// Optional direct-mapped BTB with 2-bit counters is enabled by defining FETCH_BTB_EN.
module fetch_pc_unit #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        frontend_we_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_tgt_i,
  output logic [31:0] f1_pc_o,
  output logic        f1_pred_0_o,
  output logic        f1_pred_1_o,
  output logic [31:0] f1_pred_tgt_0_o,
  output logic [31:0] f1_pred_tgt_1_o,
  output logic        f1_stall_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        advance;

  assign pc_plus8        = pc + 32'd8;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

`ifdef FETCH_BTB_EN

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       sweep_idx;
  logic                   sweep_last;
  logic                   run;

  logic [BTB_ENTRIES-1:0] btb_valid;
  btb_entry_t             btb_mem [BTB_ENTRIES];

  logic [31:0]            pc_plus4;
  logic [IDX_W-1:0]       idx0;
  logic [IDX_W-1:0]       idx1;
  logic [TAG_W-1:0]       tag0;
  logic [TAG_W-1:0]       tag1;
  btb_entry_t             entry0;
  btb_entry_t             entry1;
  logic                   hit0;
  logic                   hit1;
  logic                   pred0;
  logic                   pred1;
  logic [31:0]            tgt0;
  logic [31:0]            tgt1;

  logic [IDX_W-1:0]       upd_idx;
  logic [TAG_W-1:0]       upd_tag;
  btb_entry_t             upd_entry;
  logic                   upd_hit;
  logic                   unused_bits;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign sweep_last = (sweep_idx == IDX_W'(BTB_ENTRIES - 1));

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        sweep_idx <= sweep_idx + 1'b1;
      end
    end
  end

  // INIT sweeps every entry once, then RUN holds until the next reset.
  always_comb begin
    state_next = state;
    run        = 1'b0;
    f1_stall_o = 1'b1;
    case (state)
      ST_INIT: begin
        if (sweep_last) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        run        = 1'b1;
        f1_stall_o = 1'b0;
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign idx0     = pc[IDX_W+1:2];
  assign idx1     = pc_plus4[IDX_W+1:2];
  assign tag0     = pc[31:IDX_W+2];
  assign tag1     = pc_plus4[31:IDX_W+2];
  assign entry0   = btb_mem[idx0];
  assign entry1   = btb_mem[idx1];
  assign hit0     = btb_valid[idx0] && (entry0.tag == tag0);
  assign hit1     = btb_valid[idx1] && (entry1.tag == tag1);

  // A taken slot0 ends the fetch group, so slot1's prediction is dropped.
  assign pred0 = run && hit0 && entry0.ctr[1];
  assign pred1 = run && hit1 && entry1.ctr[1] && !pred0;
  assign tgt0  = pred0 ? {entry0.target, 2'b00} : 32'h0;
  assign tgt1  = pred1 ? {entry1.target, 2'b00} : 32'h0;

  assign f1_pred_0_o     = pred0;
  assign f1_pred_1_o     = pred1;
  assign f1_pred_tgt_0_o = tgt0;
  assign f1_pred_tgt_1_o = tgt1;

  always_comb begin
    next_pc = pc_plus8;
    if (redirect_i) begin
      next_pc = redirect_target;
    end else if (pred0) begin
      next_pc = tgt0;
    end else if (pred1) begin
      next_pc = tgt1;
    end
  end

  assign advance = run && frontend_we_i;

  assign upd_idx   = upd_pc_i[IDX_W+1:2];
  assign upd_tag   = upd_pc_i[31:IDX_W+2];
  assign upd_entry = btb_mem[upd_idx];
  assign upd_hit   = btb_valid[upd_idx] && (upd_entry.tag == upd_tag);

  // Storage has no reset of its own; the INIT sweep is what invalidates it.
  always_ff @(posedge clock_i) begin
    if (reset_n_i) begin
      if (state == ST_INIT) begin
        btb_valid[sweep_idx] <= 1'b0;
      end else if (upd_valid_i) begin
        if (upd_hit) begin
          if (upd_taken_i) begin
            btb_mem[upd_idx].ctr    <= ctr_inc(upd_entry.ctr);
            btb_mem[upd_idx].target <= upd_tgt_i[31:2];
          end else begin
            btb_mem[upd_idx].ctr <= ctr_dec(upd_entry.ctr);
          end
        end else if (upd_taken_i) begin
          btb_valid[upd_idx]      <= 1'b1;
          btb_mem[upd_idx].tag    <= upd_tag;
          btb_mem[upd_idx].target <= upd_tgt_i[31:2];
          btb_mem[upd_idx].ctr    <= 2'b10;
        end
      end
    end
  end

  assign unused_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0], upd_tgt_i[1:0]};

`else

  logic unused_bits;

  assign f1_stall_o      = 1'b0;
  assign f1_pred_0_o     = 1'b0;
  assign f1_pred_1_o     = 1'b0;
  assign f1_pred_tgt_0_o = 32'h0;
  assign f1_pred_tgt_1_o = 32'h0;

  assign next_pc = redirect_i ? redirect_target : pc_plus8;
  assign advance = frontend_we_i;

  assign unused_bits = ^{redirect_pc_i[1:0], upd_valid_i, upd_pc_i, upd_taken_i, upd_tgt_i};

`endif

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= next_pc;
    end
  end

  assign f1_pc_o = pc;

endmodule
